// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants, types and the command-to-high-time conversion used by the
// pwm_outputs block and its per-channel slices.
//   PWM_PERIOD_US : frame length in 1 MHz ticks
//   PWM_MIN_US    : pulse width for command 0 and for the disarmed/idle state
//   PWM_MAX_VAL   : command clamp ceiling (max pulse = MIN + MAX)
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int CHANNELS      = 8;
    localparam int WIDTH         = 10;
    localparam int PWM_PERIOD_US = 2500;
    localparam int PWM_MIN_US    = 1000;
    localparam int PWM_MAX_VAL   = 1000;

    localparam int CNT_W = $clog2(PWM_PERIOD_US);
    localparam int HI_W  = $clog2(PWM_MIN_US + PWM_MAX_VAL + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [HI_W-1:0]  hi_t;
    typedef logic [WIDTH-1:0] cmd_t;

    localparam cnt_t CNT_LAST = CNT_W'(PWM_PERIOD_US - 1);
    localparam hi_t  HI_IDLE  = HI_W'(PWM_MIN_US);
    localparam hi_t  HI_CEIL  = HI_W'(PWM_MIN_US + PWM_MAX_VAL);

    // Clamp a command and turn it into a pulse high-time; disarmed gives idle.
    // HI_W is sized for MIN+MAX so the sum below cannot overflow.
    function automatic hi_t cmd_to_hi(input cmd_t cmd, input logic arm);
        hi_t hi_s;
        if (arm == 1'b0) begin
            hi_s = HI_IDLE;
        end else if (HI_W'(cmd) > HI_W'(PWM_MAX_VAL)) begin
            hi_s = HI_CEIL;
        end else begin
            hi_s = HI_IDLE + HI_W'(cmd);
        end
        return hi_s;
    endfunction

endpackage

// File: rtl/pwm_outputs_if.sv
// -----------------------------------------------------------------------------
// pwm_outputs_if
// Command/PWM bundle between the controller side and the PWM generator.
//   arm        : 1 = commands pass through, 0 = idle width on every channel
//   cmd_val    : packed commands, channel i at [WIDTH*i +: WIDTH]
//   pwm_sig    : per-channel PWM outputs, active high
//   frame_sync : one-cycle strobe on the first high cycle of each frame
// master = command source (controller/bench), slave = pwm_outputs.
// -----------------------------------------------------------------------------
interface pwm_outputs_if;
    import pwm_pkg::*;

    logic                      arm;
    logic [CHANNELS*WIDTH-1:0] cmd_val;
    logic [CHANNELS-1:0]       pwm_sig;
    logic                      frame_sync;

    modport master (
        output arm,
        output cmd_val,
        input  pwm_sig,
        input  frame_sync
    );

    modport slave (
        input  arm,
        input  cmd_val,
        output pwm_sig,
        output frame_sync
    );

endinterface

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM output: holds the per-frame shadow high-time and drives a registered
// compare against the shared frame counter.
//   tmr_1Mhz : 1 MHz clock
//   rst      : asynchronous active-low reset
//   cnt      : shared frame counter (pre-edge value)
//   latch    : high on the last cycle of the frame; shadow reloads on that edge
//   arm      : arm level, only sampled with latch
//   cmd      : this channel's command, only sampled with latch
//   pwm      : registered PWM output
// -----------------------------------------------------------------------------
module pwm_channel
    import pwm_pkg::*;
(
    input  logic tmr_1Mhz,
    input  logic rst,
    input  cnt_t cnt,
    input  logic latch,
    input  logic arm,
    input  cmd_t cmd,
    output logic pwm
);

    hi_t  hi_d;
    hi_t  hi_q;
    logic pwm_d;
    logic pwm_q;

    // Shadow reload: commands only take effect at the frame boundary.
    always_comb begin
        hi_d = hi_q;
        if (latch == 1'b1) begin
            hi_d = cmd_to_hi(cmd, arm);
        end else begin
            hi_d = hi_q;
        end
    end

    // Output compare; CNT_W >= HI_W because the period exceeds the max pulse.
    always_comb begin
        pwm_d = 1'b0;
        if (cnt < CNT_W'(hi_q)) begin
            pwm_d = 1'b1;
        end else begin
            pwm_d = 1'b0;
        end
    end

    // Channel state registers with asynchronous reset to idle width, output low.
    always_ff @(posedge tmr_1Mhz or negedge rst) begin
        if (!rst) begin
            hi_q  <= HI_IDLE;
            pwm_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_outputs.sv
// -----------------------------------------------------------------------------
// pwm_outputs
// Command-to-PWM generator for CHANNELS servo/ESC outputs with a fixed frame
// period. Owns the frame counter, the end-of-frame latch strobe and frame_sync;
// each channel's shadow/clamp/compare lives in pwm_channel.
//   tmr_1Mhz : 1 MHz clock, all logic on the rising edge
//   rst      : asynchronous active-low reset
//   bus      : pwm_outputs_if slave (arm, cmd_val in; pwm_sig, frame_sync out)
// After reset the first frame always runs at idle width; commands apply from
// the second frame on.
// -----------------------------------------------------------------------------
module pwm_outputs
    import pwm_pkg::*;
(
    input  logic          tmr_1Mhz,
    input  logic          rst,
    pwm_outputs_if.slave  bus
);

    // The whole frame must fit the longest pulse plus at least one low cycle.
    if (PWM_PERIOD_US <= PWM_MIN_US + PWM_MAX_VAL) begin : g_bad_params
        $fatal(1, "pwm_outputs: PWM_PERIOD_US must exceed PWM_MIN_US+PWM_MAX_VAL");
    end

    cnt_t                cnt_d;
    cnt_t                cnt_q;
    logic                latch_s;
    logic                frame_sync_d;
    logic                frame_sync_q;
    logic [CHANNELS-1:0] pwm_s;

    assign latch_s = (cnt_q == CNT_LAST);

    // Frame counter next state: wrap on the latch cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (latch_s == 1'b1) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // frame_sync lines up with the edge where every channel rises (cnt==0 pre-edge).
    always_comb begin
        frame_sync_d = 1'b0;
        if (cnt_q == {CNT_W{1'b0}}) begin
            frame_sync_d = 1'b1;
        end else begin
            frame_sync_d = 1'b0;
        end
    end

    // Frame counter and frame_sync registers.
    always_ff @(posedge tmr_1Mhz or negedge rst) begin
        if (!rst) begin
            cnt_q        <= {CNT_W{1'b0}};
            frame_sync_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        pwm_channel u_channel (
            .tmr_1Mhz (tmr_1Mhz),
            .rst      (rst),
            .cnt      (cnt_q),
            .latch    (latch_s),
            .arm      (bus.arm),
            .cmd      (bus.cmd_val[WIDTH*ch +: WIDTH]),
            .pwm      (pwm_s[ch])
        );
    end

    assign bus.pwm_sig    = pwm_s;
    assign bus.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_pwm_outputs.sv
// -----------------------------------------------------------------------------
// tb_pwm_outputs
// Self-checking bench for pwm_outputs. The reference model is the frame-level
// rule: each frame every channel is high for its width starting on the first
// cycle, and the width for the next frame comes from arm/cmd as they stand
// just before the last edge of the current frame.
// -----------------------------------------------------------------------------
module tb_pwm_outputs;

    localparam int N_CH     = 8;
    localparam int T_PERIOD = 2500;
    localparam int T_MIN    = 1000;
    localparam int T_MAX    = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cur_hi[N_CH];

    logic [N_CH*10-1:0] cmd_v;

    pwm_outputs_if bus ();

    pwm_outputs dut (
        .tmr_1Mhz (clk),
        .rst      (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_width(input bit a, input int c);
        if (!a) return T_MIN;
        return T_MIN + ((c > T_MAX) ? T_MAX : c);
    endfunction

    function automatic logic [N_CH*10-1:0] set_ch(input logic [N_CH*10-1:0] v,
                                                  input int ch, input int val);
        logic [N_CH*10-1:0] r;
        r = v;
        r[ch*10 +: 10] = val[9:0];
        return r;
    endfunction

    // Observe one whole frame, optionally changing inputs after cycle chg_at.
    task automatic run_frame(input string name, input int chg_at,
                             input logic new_arm, input logic [N_CH*10-1:0] new_cmd);
        int hi_cnt[N_CH];
        int bad[N_CH];
        int nxt[N_CH];
        int sync_bad;
        sync_bad = 0;
        for (int i = 0; i < N_CH; i++) begin
            hi_cnt[i] = 0;
            bad[i]    = 0;
            nxt[i]    = cur_hi[i];
        end
        for (int j = 0; j < T_PERIOD; j++) begin
            @(posedge clk);
            #1;
            if (bus.frame_sync !== ((j == 0) ? 1'b1 : 1'b0)) sync_bad++;
            for (int i = 0; i < N_CH; i++) begin
                logic e;
                e = (j < cur_hi[i]) ? 1'b1 : 1'b0;
                if (bus.pwm_sig[i] !== e) bad[i]++;
                if (bus.pwm_sig[i] === 1'b1) hi_cnt[i]++;
            end
            // Inputs as they stood before the last edge define the next frame.
            if (j == T_PERIOD - 1) begin
                for (int i = 0; i < N_CH; i++)
                    nxt[i] = exp_width(bus.arm, int'(bus.cmd_val[i*10 +: 10]));
            end
            if (j == chg_at) begin
                bus.arm     = new_arm;
                bus.cmd_val = new_cmd;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (bad[i] != 0) begin
                failures++;
                $display("FAIL %s ch%0d: got %0d high cycles (%0d misplaced), expected %0d from frame start",
                         name, i, hi_cnt[i], bad[i], cur_hi[i]);
            end
        end
        checks++;
        if (sync_bad != 0) begin
            failures++;
            $display("FAIL %s frame_sync: %0d wrong cycles, expected high only on first cycle",
                     name, sync_bad);
        end
        cur_hi = nxt;
    endtask

    task automatic test_reset();
        bus.arm     = 1'b1;
        cmd_v       = '0;
        cmd_v       = set_ch(cmd_v, 0, 500);
        bus.cmd_val = cmd_v;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.pwm_sig !== 8'h00 || bus.frame_sync !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: pwm_sig=%h frame_sync=%b, expected 00/0",
                         bus.pwm_sig, bus.frame_sync);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_CH; i++) cur_hi[i] = T_MIN;
    endtask

    task automatic test_startup();
        run_frame("startup_f1", -1, 1'b1, cmd_v);
        run_frame("startup_f2", -1, 1'b1, cmd_v);
        run_frame("startup_f3", -1, 1'b1, cmd_v);
    endtask

    task automatic test_clamp();
        cmd_v = set_ch(cmd_v, 1, 1023);
        cmd_v = set_ch(cmd_v, 2, 0);
        cmd_v = set_ch(cmd_v, 3, 1000);
        run_frame("clamp_load", 10, 1'b1, cmd_v);
        run_frame("clamp", -1, 1'b1, cmd_v);
    endtask

    task automatic test_mid_frame_change();
        cmd_v = set_ch(cmd_v, 0, 800);
        run_frame("mid_load", 5, 1'b1, cmd_v);
        cmd_v = set_ch(cmd_v, 0, 100);
        run_frame("mid_changed", 1200, 1'b1, cmd_v);
        run_frame("mid_next", -1, 1'b1, cmd_v);
    endtask

    task automatic test_arm();
        for (int i = 0; i < N_CH; i++) cmd_v = set_ch(cmd_v, i, 700);
        run_frame("arm_load", 5, 1'b0, cmd_v);
        run_frame("arm_raise", 1300, 1'b1, cmd_v);
        run_frame("arm_on", -1, 1'b1, cmd_v);
    endtask

    task automatic test_latch_boundary();
        run_frame("late_drop", T_PERIOD - 1, 1'b0, cmd_v);
        run_frame("drop_seen", T_PERIOD - 2, 1'b1, cmd_v);
        run_frame("raise_seen", -1, 1'b1, cmd_v);
        run_frame("armed_again", -1, 1'b1, cmd_v);
    endtask

    task automatic test_reset_mid();
        logic [N_CH-1:0] exp_v;
        cmd_v = set_ch(cmd_v, 0, 900);
        run_frame("rst_setup", 5, 1'b1, cmd_v);
        for (int k = 0; k < 500; k++) @(posedge clk);
        #3;
        for (int i = 0; i < N_CH; i++) exp_v[i] = (499 < cur_hi[i]) ? 1'b1 : 1'b0;
        checks++;
        if (bus.pwm_sig !== exp_v) begin
            failures++;
            $display("FAIL pre_reset_level: pwm_sig=%h expected %h", bus.pwm_sig, exp_v);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pwm_sig !== 8'h00 || bus.frame_sync !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pwm_sig=%h frame_sync=%b, expected 00/0 before any edge",
                     bus.pwm_sig, bus.frame_sync);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_CH; i++) cur_hi[i] = T_MIN;
        run_frame("after_rst_f1", -1, 1'b1, cmd_v);
        run_frame("after_rst_f2", -1, 1'b1, cmd_v);
    endtask

    task automatic test_all_channels();
        for (int i = 0; i < N_CH; i++) cmd_v = set_ch(cmd_v, i, 150 * i);
        run_frame("allch_load", 5, 1'b1, cmd_v);
        run_frame("allch_f1", -1, 1'b1, cmd_v);
        run_frame("allch_f2", -1, 1'b1, cmd_v);
        run_frame("allch_f3", -1, 1'b1, cmd_v);
    endtask

    task automatic test_random();
        logic a;
        int   at;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N_CH; i++) cmd_v = set_ch(cmd_v, i, int'($urandom_range(1023, 0)));
            a  = ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0;
            at = int'($urandom_range(T_PERIOD - 1, 0));
            run_frame("random", at, a, cmd_v);
        end
        run_frame("random_tail", -1, 1'b1, cmd_v);
    endtask

    initial begin
        bus.arm     = 1'b0;
        bus.cmd_val = '0;
        test_reset();
        test_startup();
        test_clamp();
        test_mid_frame_change();
        test_arm();
        test_latch_boundary();
        test_reset_mid();
        test_all_channels();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_outputs.md
Name: pwm_outputs

Overview:
- Command-to-PWM generator for 8 servo/ESC channels.
- Converts 10-bit command values into fixed-period PWM pulses timed by the 1 MHz tick clock.
- Complements the radio decode path: the receive side turns pulse widths into values, and this block turns values into pulse widths.
- Sits between the controller/mixer and the actuator pins.

Parameters:
- CHANNELS, 8, number of PWM outputs.
- WIDTH, 10, bits per command value.
- PERIOD_US, 2500, frame period in clock cycles (µs); 2500 gives 400 Hz.
- MIN_US, 1000, pulse width in µs for command value 0; also the idle/disarmed width.
- MAX_VAL, 1000, command clamp ceiling; maximum pulse is MIN_US+MAX_VAL.

Ports:
- tmr_1Mhz  in  1  1 MHz clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- arm  in  1  1 = pass commands through; 0 = force idle width on all channels.
- cmd_val  in  CHANNELS*WIDTH  packed commands; channel i occupies [WIDTH*i+WIDTH-1 : WIDTH*i].
- pwm_sig  out  CHANNELS  PWM outputs, active high.
- frame_sync  out  1  one-cycle strobe marking the first cycle of each frame.

Behaviour:
- Reset (rst=0, async):
  - pwm_sig=0, frame_sync=0.
  - Frame counter cnt=0.
  - Every channel's shadow high-time hi[i]=MIN_US.
  - Takes effect immediately, including mid-pulse.
- Frame counter:
  - cnt width is clog2(PERIOD_US).
  - Increments by 1 per clock.
  - At cnt==PERIOD_US-1 it wraps to 0.
- Shadow latch (at the edge where cnt==PERIOD_US-1, same edge as the wrap):
  - hi[i] <= MIN_US + min(cmd_val_i, MAX_VAL) if arm=1; else MIN_US.
  - arm and cmd_val are sampled only here; changes mid-frame never alter the current pulse.
  - hi width is clog2(MIN_US+MAX_VAL+1) bits (11 at defaults); the addition cannot overflow.
- Output (registered):
  - On every edge, pwm_sig[i] <= (cnt < hi[i]), using pre-edge values.
  - The pulse rises on the edge after cnt becomes 0.
  - The pulse is high for exactly hi[i] cycles, and all channels rise on the same edge.
- frame_sync: registered, high for exactly the one cycle in which pwm_sig rises, i.e. once per PERIOD_US cycles.
- First frame after reset release:
  - cnt counts from 0 with reset shadows, so every channel outputs MIN_US.
  - Commands take effect from the second frame onward, giving a safe ESC idle at startup.
- Latency: a command change reaches the output at the next frame boundary; worst case PERIOD_US+1 cycles.
- Boundaries:
  - cmd_val_i > MAX_VAL (e.g. 1023) is clamped to MAX_VAL.
  - cmd_val_i=0 produces MIN_US.
  - arm and cmd_val changing in the same cycle as the latch edge: the pre-edge values are used.
  - Reset asserted mid-frame: outputs drop low immediately. After release, the first full frame starts with cnt=0 and idle widths.
- Elaboration check: PERIOD_US > MIN_US+MAX_VAL. A violating parameter set is a fatal elaboration error.

Decomposition:
- Shared package pwm_pkg holds:
  - localparams PWM_PERIOD_US, PWM_MIN_US, PWM_MAX_VAL.
  - Derived counter and high-time widths.
  - The clamp/width function (cmd -> hi).
- Sub-module pwm_channel: one per channel, generated CHANNELS times.
  - Contains the shadow register, clamp and registered compare.
  - Inputs: shared cnt, latch strobe, arm, command.
- The top level owns the frame counter, latch strobe generation, frame_sync and unpacking of cmd_val.

Test Plan:
- Reset release, arm=1, ch0=500 held:
  - Frame 1: pwm_sig[0] high 1000 cycles.
  - Frame 2 onward: high 1500 cycles.
  - Rising edges exactly 2500 cycles apart; frame_sync high 1 cycle coincident with each rise.
- Clamp:
  - ch1=1023 -> 2000-cycle pulse.
  - ch2=0 -> 1000-cycle pulse.
  - ch3=1000 -> 2000-cycle pulse.
- Mid-frame change: ch0=800, switched to 100 at cnt=1200 -> current pulse 1800 cycles, next frame 1100 cycles.
- arm=0 with all channels=700:
  - All pulses 1000 cycles.
  - arm raised mid-frame leaves the current frame at 1000; the next frame is 1700.
- Reset asserted at cnt=500 with ch0=900:
  - pwm_sig and frame_sync go 0 within the same cycle, without a clock edge.
  - After release: first frame 1000 cycles, second frame 1900.
- All 8 channels at 0,150,...,1050:
  - All rise on the same edge.
  - Widths 1000,1150,...,1900,2000, with ch7 clamped.
  - No cross-channel interference over 3 frames.
